// File: rtl/fp32_accumulator.sv
// fp32_accumulator: multi-cycle IEEE-754 single-precision running-sum adder (align/add/normalize FSM).
// Optional macro FP_ACC_GRS_ROUND_EN keeps guard/round/sticky bits and adds a round-to-nearest-even stage.
module fp32_accumulator #(
  parameter int unsigned NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_ovf,
  input  logic        in_unf,
  output logic [31:0] acc_out,
  output logic        out_valid,
  output logic        busy,
  output logic        sticky_ovf,
  output logic        sticky_unf
);
`ifdef FP_ACC_GRS_ROUND_EN
  localparam int unsigned XW = 3;
`else
  localparam int unsigned XW = 0;
`endif
  localparam int unsigned SW   = 24 + XW;
  localparam logic [4:0]  STEP = 5'(NORM_STEP);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (!(NORM_STEP == 1 || NORM_STEP == 2 || NORM_STEP == 4)) begin : g_bad_norm_step
    $error("fp32_accumulator: NORM_STEP must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_WRITE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   op_q, op_d, acc_q, acc_d, res_q, res_d;
  logic          out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          sign_q, sign_d, sub_q, sub_d;
  logic [7:0]    exp_q, exp_d;
  logic [SW-1:0] a_sig_q, a_sig_d, b_sig_q, b_sig_d;
  logic [SW:0]   sig_q, sig_d;

  logic [7:0]    ea, eb, big_e, small_e, diff;
  logic [23:0]   ma, mb, big_m, small_m;
  logic          za, zb, nan_a, nan_b, inf_a, inf_b, acc_big, big_s, norm_done;
  logic [SW-1:0] a_al, b_al;
  logic [SW:0]   sum, sig_rs, sig_sl;
  logic [4:0]    lz, sh;

  // Operand decode: A side is the running sum, B side the latched product
  assign ea    = acc_q[30:23];
  assign eb    = op_q[30:23];
  assign ma    = {1'b1, acc_q[22:0]};
  assign mb    = {1'b1, op_q[22:0]};
  assign za    = (ea == 8'h00);
  assign zb    = (eb == 8'h00);
  assign nan_a = (ea == 8'hFF) && (acc_q[22:0] != 23'h0);
  assign nan_b = (eb == 8'hFF) && (op_q[22:0] != 23'h0);
  assign inf_a = (ea == 8'hFF) && (acc_q[22:0] == 23'h0);
  assign inf_b = (eb == 8'hFF) && (op_q[22:0] == 23'h0);

  assign acc_big = (ea > eb) || ((ea == eb) && (ma >= mb));
  assign big_e   = acc_big ? ea : eb;
  assign small_e = acc_big ? eb : ea;
  assign big_m   = acc_big ? ma : mb;
  assign small_m = acc_big ? mb : ma;
  assign big_s   = acc_big ? acc_q[31] : op_q[31];
  assign diff    = big_e - small_e;

`ifdef FP_ACC_GRS_ROUND_EN
  logic [51:0] wide;
  logic        round_up;
  logic [24:0] rnd_m;
  assign wide     = {small_m, 28'h0} >> diff;
  assign a_al     = {big_m, 3'b000};
  assign b_al     = (diff >= 8'd27) ? 27'd1 : {wide[51:26], |wide[25:0]};
  assign sig_rs   = {1'b0, sig_q[SW:2], sig_q[1] | sig_q[0]};
  assign round_up = sig_q[2] & (sig_q[3] | sig_q[1] | sig_q[0]);
  assign rnd_m    = {1'b0, sig_q[26:3]} + 25'(round_up);
`else
  assign a_al   = big_m;
  assign b_al   = (diff >= 8'd25) ? 24'd0 : (small_m >> diff);
  assign sig_rs = {1'b0, sig_q[SW:1]};
`endif

  assign sum    = sub_q ? ({1'b0, a_sig_q} - {1'b0, b_sig_q}) : ({1'b0, a_sig_q} + {1'b0, b_sig_q});
  assign sig_sl = {1'b0, sig_q[SW-1:0] << sh};

  // Leading zeros of the working significand below the carry bit
  always_comb begin
    lz = 5'(SW);
    for (int i = 0; i < int'(SW); i++) begin
      if (sig_q[i]) lz = 5'(int'(SW) - 1 - i);
    end
  end
  assign sh = (lz < STEP) ? lz : STEP;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    exp_d       = exp_q;
    a_sig_d     = a_sig_q;
    b_sig_d     = b_sig_q;
    sig_d       = sig_q;
    norm_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          ovf_d   = ovf_q | in_ovf;
          unf_d   = unf_q | in_unf;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_WRITE;
        if (nan_a || nan_b || (inf_a && inf_b && (acc_q[31] != op_q[31]))) res_d = QNAN;
        else if (inf_a)    res_d = acc_q;
        else if (inf_b)    res_d = op_q;
        else if (za && zb) res_d = {acc_q[31] & op_q[31], 31'h0};
        else if (za)       res_d = op_q;
        else if (zb)       res_d = acc_q;
        else begin
          sign_d  = big_s;
          sub_d   = acc_q[31] ^ op_q[31];
          exp_d   = big_e;
          a_sig_d = a_al;
          b_sig_d = b_al;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sig_d = sum;
        if (sum == '0) begin
          res_d   = 32'h0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (sig_q[SW]) begin
          norm_done = 1'b1;
          if (exp_q == 8'd254) begin
            exp_d = 8'hFF;
            sig_d = '0;
            ovf_d = 1'b1;
          end else begin
            exp_d = exp_q + 8'd1;
            sig_d = sig_rs;
          end
        end else if (exp_q <= 8'(sh)) begin
          norm_done = 1'b1;
          exp_d     = 8'h00;
          sig_d     = '0;
          sign_d    = 1'b0;
          unf_d     = 1'b1;
        end else begin
          exp_d     = exp_q - 8'(sh);
          sig_d     = sig_sl;
          norm_done = (lz <= STEP);
        end
        if (norm_done) begin
`ifdef FP_ACC_GRS_ROUND_EN
          state_d = ST_ROUND;
`else
          res_d   = {sign_d, exp_d, sig_d[SW-2:XW]};
          state_d = ST_WRITE;
`endif
        end
      end
`ifdef FP_ACC_GRS_ROUND_EN
      ST_ROUND: begin
        state_d = ST_WRITE;
        if (!rnd_m[24]) begin
          res_d = {sign_q, exp_q, 23'(rnd_m)};
        end else if (exp_q == 8'd254) begin
          res_d = {sign_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else begin
          res_d = {sign_q, exp_q + 8'd1, 23'h0};
        end
      end
`endif
      ST_WRITE: begin
        acc_d       = res_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over everything, including an accept in the same cycle
    if (clear) begin
      state_d     = ST_IDLE;
      acc_d       = 32'h0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 32'h0;
      acc_q       <= 32'h0;
      res_q       <= 32'h0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= 8'h00;
      a_sig_q     <= '0;
      b_sig_q     <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      exp_q       <= exp_d;
      a_sig_q     <= a_sig_d;
      b_sig_q     <= b_sig_d;
      sig_q       <= sig_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && !clear;
  assign busy       = (state_q != ST_IDLE);
  assign acc_out    = acc_q;
  assign out_valid  = out_valid_q;
  assign sticky_ovf = ovf_q;
  assign sticky_unf = unf_q;

endmodule

// File: tb/tb_fp32_accumulator.sv
// Bench for fp32_accumulator: vector table with scoreboard, plus clear/reset corner sequences.
module tb_fp32_accumulator;
`ifdef FP_ACC_GRS_ROUND_EN
  localparam int RND = 1;
  localparam logic [31:0] EXP3 = 32'h3380_0000;
  localparam int N3 = 24;
`else
  localparam int RND = 0;
  localparam logic [31:0] EXP3 = 32'h3400_0000;
  localparam int N3 = 23;
`endif

  // n: -1 special path, 0 exact cancellation, >0 normalize cycles
  typedef struct packed {
    logic        clr;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic [31:0] acc;
    int          n;
    logic        sovf;
    logic        sunf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ovf, in_unf;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, sticky_ovf, sticky_unf;
  logic [31:0] acc_out;
  logic        clear4, in_valid4;
  logic [31:0] in_data4;
  logic        in_ready4, out_valid4, busy4, sticky_ovf4, sticky_unf4;
  logic [31:0] acc_out4;

  int   total = 0;
  int   bad = 0;
  vec_t tbl [21];
  vec_t sb_q [$];
  vec_t mon_v;

  always #5 clk = ~clk;

  fp32_accumulator #(.NORM_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ovf(in_ovf), .in_unf(in_unf), .acc_out(acc_out),
    .out_valid(out_valid), .busy(busy), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
  );

  fp32_accumulator #(.NORM_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_ovf(1'b0), .in_unf(1'b0), .acc_out(acc_out4),
    .out_valid(out_valid4), .busy(busy4), .sticky_ovf(sticky_ovf4), .sticky_unf(sticky_unf4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got acc %h expected no pulse at %0t", acc_out, $time);
      end else begin
        mon_v = sb_q.pop_front();
        chk("acc_out", acc_out, mon_v.acc);
        chk("sticky_ovf", 32'(sticky_ovf), 32'(mon_v.sovf));
        chk("sticky_unf", 32'(sticky_unf), 32'(mon_v.sunf));
      end
    end
  end

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("ready_while_clear", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_acc", acc_out, 32'h0);
    chk("clear_ovf", 32'(sticky_ovf), 32'd0);
    chk("clear_unf", 32'(sticky_unf), 32'd0);
  endtask

  task automatic apply(input vec_t v);
    int n;
    int lat;
    lat = (v.n < 0) ? 2 : ((v.n == 0) ? 3 : 3 + v.n + RND);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    in_valid = 1'b1; in_data = v.data; in_ovf = v.ovf; in_unf = v.unf;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = $urandom; in_ovf = 1'b0; in_unf = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(lat));
    chk("ready_with_out_valid", 32'(in_ready), 32'd1);
  endtask

  task automatic op4(input logic [31:0] d, input logic [31:0] exp_acc, input int exp_lat);
    int n;
    @(negedge clk);
    chk("dut4_ready", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; in_data4 = d;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    chk("dut4_busy", 32'(busy4), 32'd1);
    n = 0;
    while (!out_valid4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("dut4_latency", 32'(n), 32'(exp_lat));
    chk("dut4_acc", acc_out4, exp_acc);
    chk("dut4_flags", 32'({sticky_ovf4, sticky_unf4}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_ovf = 1'b0; in_unf = 1'b0;
    clear4 = 1'b0; in_valid4 = 1'b0; in_data4 = 32'h0;

    tbl[0]  = '{1'b1, 32'h4020_0000, 1'b0, 1'b0, 32'h4020_0000, -1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h4020_0000, 1'b0, 1'b0, 32'h40A0_0000,  1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h40C8_0000, 1'b0, 1'b0, 32'h40C8_0000, -1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'hC0C8_0000, 1'b0, 1'b0, 32'h0000_0000,  0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, -1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'hBF7F_FFFF, 1'b0, 1'b0, EXP3,          N3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h7F7F_FFFF, 1'b0, 1'b0, 32'h7F7F_FFFF, -1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h7F7F_FFFF, 1'b0, 1'b0, 32'h7F80_0000,  1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'hFF80_0000, 1'b0, 1'b0, 32'h7FC0_0000, -1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, -1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h3F80_0000, 1'b1, 1'b0, 32'h3F80_0000,  1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, -1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h3F00_0000, 1'b0, 1'b0, 32'h3FC0_0000,  1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'hC000_0000, 1'b0, 1'b0, 32'hBF00_0000,  2, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h0080_0000, 1'b0, 1'b0, 32'h0080_0000, -1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 32'h80C0_0000, 1'b0, 1'b0, 32'h0000_0000,  1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, -1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 32'h0000_0001, 1'b0, 1'b0, 32'h3F80_0000, -1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 32'h3300_0000, 1'b0, 1'b0, 32'h3F80_0000,  1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, -1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, -1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc_out, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].clr) do_clear();
      apply(tbl[i]);
    end

    // NORM_STEP=4 instance: same cancellation-heavy case in fewer normalize cycles
    op4(32'h3F80_0000, 32'h3F80_0000, 2);
    op4(32'hBF7F_FFFF, EXP3, 3 + 6 + RND);

    // Clear two cycles after an accept aborts the operation
    do_clear();
    apply('{1'b0, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, -1, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h3F00_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_before_clear", 32'(busy), 32'd1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("abort_acc", acc_out, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("abort_no_pulse", 32'(cnt), 32'd0);

    // Clear together with in_valid in IDLE: product is not accepted
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h4000_0000;
    #1;
    chk("clear_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    #1;
    chk("clear_valid_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid || busy) cnt++; end
    chk("clear_valid_ignored", 32'(cnt), 32'd0);
    chk("clear_valid_acc", acc_out, 32'h0);

    // Asynchronous reset in the middle of a long normalization
    apply('{1'b0, 32'h3F80_0000, 1'b1, 1'b1, 32'h3F80_0000, -1, 1'b1, 1'b1});
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hBF7F_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_norm", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_acc", acc_out, 32'h0);
    chk("async_rst_flags", 32'({out_valid, busy, sticky_ovf, sticky_unf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) cnt++; end
    chk("rst_discards_op", 32'(cnt), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
